// File: rtl/player_anim_fsm_if.sv
// Player animation sequencer bus: key/serve/point-end inputs plus pose and ball/step outputs.
// master drives the inputs (game logic or bench); slave is the sequencer.
interface player_anim_fsm_if #(
    parameter int POSE_W = 6
);
    logic [7:0]        keycode;
    logic              has_serve;
    logic              point_end;
    logic [POSE_W-1:0] pose;
    logic              ball_exist;
    logic              ball_shoot;
    logic              ball_hit;
    logic              step_l;
    logic              step_r;

    modport master (
        output keycode, has_serve, point_end,
        input  pose, ball_exist, ball_shoot, ball_hit, step_l, step_r
    );

    modport slave (
        input  keycode, has_serve, point_end,
        output pose, ball_exist, ball_shoot, ball_hit, step_l, step_r
    );
endinterface

// File: rtl/player_anim_fsm.sv
// Per-player badminton sequencer: keycode -> pose index, ball flags and step pulses; registered, one frame after the key edge, no backpressure.
// Idle auto-serve is enabled by defining PLAYER_AUTO_SERVE_EN.
module player_anim_fsm #(
    parameter logic [7:0] KEY_LEFT          = 8'h50,
    parameter logic [7:0] KEY_RIGHT         = 8'h4F,
    parameter logic [7:0] KEY_HIT           = 8'h51,
    parameter int         SERVE_LEN         = 6,
    parameter int         SHOOT_FRAME       = 2,
    parameter int         HIT_LEN           = 5,
    parameter int         HIT_ACTIVE        = 3,
    parameter int         MOVE_LEN          = 3,
    parameter int         COOLDOWN_LEN      = 4,
    parameter int         AUTO_SERVE_FRAMES = 120,
    parameter int         POSE_W            = 6
) (
    input  logic             frame_clk,
    input  logic             Reset,
    player_anim_fsm_if.slave bus
);
    localparam int CD_W = (COOLDOWN_LEN > 0) ? $clog2(COOLDOWN_LEN + 1) : 1;
    localparam logic [POSE_W-1:0] P_R  = POSE_W'(SERVE_LEN + 1);
    localparam logic [POSE_W-1:0] P_M  = POSE_W'(SERVE_LEN + 2 + HIT_LEN);
    localparam logic [POSE_W-1:0] P_SM = POSE_W'(SERVE_LEN + 2 + HIT_LEN + MOVE_LEN);

    typedef enum logic [2:0] {S_IDLE, S_SWING, S_MOVE, R_IDLE, R_HIT, R_MOVE} state_t;

    typedef struct packed {
        logic [POSE_W-1:0] pose;
        logic              exist;
        logic              shoot;
        logic              hit;
        logic              step_l;
        logic              step_r;
    } out_t;

    state_t            state, state_n;
    logic [POSE_W-1:0] k, k_n;
    logic              move_r, move_r_n;
    logic [CD_W-1:0]   cool, cool_n;
    logic [7:0]        prev_key;
    out_t              out_q;

`ifdef PLAYER_AUTO_SERVE_EN
    localparam int IC_W = $clog2(AUTO_SERVE_FRAMES + 1);
    logic [IC_W-1:0] idle_cnt, idle_cnt_n;
`endif

    // Outputs are a pure function of (state, k, direction); decoding the next
    // state lets them be registered without adding a frame of latency.
    function automatic out_t decode(input state_t s, input logic [POSE_W-1:0] kk, input logic mr);
        out_t o;
        o       = '0;
        o.exist = 1'b1;
        o.pose  = P_R;
        case (s)
            S_IDLE: begin
                o.pose  = '0;
                o.exist = 1'b0;
            end
            S_SWING: begin
                o.pose  = POSE_W'(1) + kk;
                o.exist = (kk >= POSE_W'(SHOOT_FRAME));
                o.shoot = (kk == POSE_W'(SHOOT_FRAME));
            end
            S_MOVE, R_MOVE: begin
                o.pose   = mr ? ((s == S_MOVE ? P_SM : P_M) + kk)
                              : ((s == S_MOVE ? P_SM : P_M) + POSE_W'(MOVE_LEN - 1) - kk);
                o.exist  = (s == R_MOVE);
                o.step_r = mr && (kk == '0);
                o.step_l = !mr && (kk == '0);
            end
            R_HIT: begin
                o.pose = P_R + POSE_W'(1) + kk;
                o.hit  = (kk < POSE_W'(HIT_ACTIVE));
            end
            default: o.pose = P_R;
        endcase
        return o;
    endfunction

    always_comb begin
        state_n  = state;
        k_n      = '0;
        move_r_n = move_r;
        cool_n   = (cool != '0) ? cool - CD_W'(1) : '0;
`ifdef PLAYER_AUTO_SERVE_EN
        idle_cnt_n = '0;
`endif
        case (state)
            S_IDLE: begin
                if (bus.keycode == KEY_HIT) begin
                    state_n = S_SWING;
                end else if (bus.keycode == KEY_LEFT) begin
                    state_n  = S_MOVE;
                    move_r_n = 1'b0;
                end else if (bus.keycode == KEY_RIGHT) begin
                    state_n  = S_MOVE;
                    move_r_n = 1'b1;
                end
`ifdef PLAYER_AUTO_SERVE_EN
                else if (idle_cnt + IC_W'(1) == IC_W'(AUTO_SERVE_FRAMES)) begin
                    state_n = S_SWING;
                end else begin
                    idle_cnt_n = idle_cnt + IC_W'(1);
                end
`endif
            end
            S_SWING: begin
                if (k == POSE_W'(SERVE_LEN - 1)) state_n = R_IDLE;
                else                             k_n     = k + POSE_W'(1);
            end
            R_IDLE: begin
                // A hit needs a fresh press and an expired cooldown; a held key never re-swings.
                if (bus.keycode == KEY_HIT) begin
                    if (prev_key != KEY_HIT && cool == '0) state_n = R_HIT;
                end else if (bus.keycode == KEY_LEFT) begin
                    state_n  = R_MOVE;
                    move_r_n = 1'b0;
                end else if (bus.keycode == KEY_RIGHT) begin
                    state_n  = R_MOVE;
                    move_r_n = 1'b1;
                end
            end
            R_HIT: begin
                if (k == POSE_W'(HIT_LEN - 1)) begin
                    state_n = R_IDLE;
                    cool_n  = CD_W'(COOLDOWN_LEN);
                end else begin
                    k_n = k + POSE_W'(1);
                end
            end
            S_MOVE, R_MOVE: begin
                if (k == POSE_W'(MOVE_LEN - 1)) state_n = (state == S_MOVE) ? S_IDLE : R_IDLE;
                else                            k_n     = k + POSE_W'(1);
            end
            default: state_n = R_IDLE;
        endcase

        if (bus.point_end) begin
            state_n = bus.has_serve ? S_IDLE : R_IDLE;
            k_n     = '0;
            cool_n  = '0;
`ifdef PLAYER_AUTO_SERVE_EN
            idle_cnt_n = '0;
`endif
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= R_IDLE;
            k        <= '0;
            move_r   <= 1'b0;
            cool     <= '0;
            prev_key <= '0;
            out_q    <= decode(R_IDLE, '0, 1'b0);
`ifdef PLAYER_AUTO_SERVE_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            k        <= k_n;
            move_r   <= move_r_n;
            cool     <= cool_n;
            prev_key <= bus.keycode;
            out_q    <= decode(state_n, k_n, move_r_n);
`ifdef PLAYER_AUTO_SERVE_EN
            idle_cnt <= idle_cnt_n;
`endif
        end
    end

    assign bus.pose       = out_q.pose;
    assign bus.ball_exist = out_q.exist;
    assign bus.ball_shoot = out_q.shoot;
    assign bus.ball_hit   = out_q.hit;
    assign bus.step_l     = out_q.step_l;
    assign bus.step_r     = out_q.step_r;
endmodule

// File: tb/tb_player_anim_fsm.sv
// Bench for player_anim_fsm: per-frame vectors queued as expectations, compared one edge later.
module tb_player_anim_fsm;
    localparam logic [7:0] K_L = 8'h50;
    localparam logic [7:0] K_R = 8'h4F;
    localparam logic [7:0] K_H = 8'h51;

    typedef struct {
        string       tag;
        logic        rst;
        logic [7:0]  key;
        logic        hs;
        logic        pe;
        logic [10:0] exp;   // {pose[5:0], exist, shoot, hit, step_l, step_r}
    } vec_t;

    logic frame_clk;
    logic Reset;
    int   checks;
    int   errors;
    vec_t exp_q[$];
    vec_t tbl[$];
    vec_t mon_e;
    logic [10:0] mon_act;

    player_anim_fsm_if #(.POSE_W(6)) bus ();

    player_anim_fsm dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic vec_t mk(input string tag, input logic rst, input logic [7:0] key,
                                input logic hs, input logic pe, input int pose,
                                input logic ex, input logic sh, input logic hi,
                                input logic sl, input logic sr);
        vec_t v;
        v.tag = tag;
        v.rst = rst;
        v.key = key;
        v.hs  = hs;
        v.pe  = pe;
        v.exp = {6'(pose), ex, sh, hi, sl, sr};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge frame_clk);
        Reset         = v.rst;
        bus.keycode   = v.key;
        bus.has_serve = v.hs;
        bus.point_end = v.pe;
        exp_q.push_back(v);
    endtask

    // Each edge consumes the oldest queued expectation.
    always @(posedge frame_clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {bus.pose, bus.ball_exist, bus.ball_shoot, bus.ball_hit, bus.step_l, bus.step_r};
            checks++;
            if (mon_act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s check %0d: got pose=%0d flags(ex,sh,hit,l,r)=%b, want pose=%0d flags=%b",
                         mon_e.tag, checks, mon_act[10:5], mon_act[4:0], mon_e.exp[10:5], mon_e.exp[4:0]);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        Reset         = 1'b1;
        bus.keycode   = 8'h00;
        bus.has_serve = 1'b0;
        bus.point_end = 1'b0;

        // reset and idle stability
        tbl.push_back(mk("reset", 1, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk("idle", 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));

        // held hit: one swing only
        tbl.push_back(mk("hit", 0, K_H, 0, 0,  8, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit", 0, K_H, 0, 0,  9, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit", 0, K_H, 0, 0, 10, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit", 0, K_H, 0, 0, 11, 1, 0, 0, 0, 0));
        tbl.push_back(mk("hit", 0, K_H, 0, 0, 12, 1, 0, 0, 0, 0));
        for (int i = 0; i < 15; i++) tbl.push_back(mk("hit_hold", 0, K_H, 0, 0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk("release", 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));

        // cooldown: swing, return, press 2 frames later refused, press 5 frames later accepted
        tbl.push_back(mk("hit2", 0, K_H,   0, 0,  8, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit2", 0, 8'h00, 0, 0,  9, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit2", 0, 8'h00, 0, 0, 10, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit2", 0, 8'h00, 0, 0, 11, 1, 0, 0, 0, 0));
        tbl.push_back(mk("hit2", 0, 8'h00, 0, 0, 12, 1, 0, 0, 0, 0));
        tbl.push_back(mk("hit2_ret", 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk("cool_wait", 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk("cool_refuse", 0, K_H, 0, 0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk("cool_wait", 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk("cool_wait", 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk("cool_accept", 0, K_H, 0, 0, 8, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit3", 0, 8'h00, 0, 0,  9, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit3", 0, 8'h00, 0, 0, 10, 1, 0, 1, 0, 0));
        tbl.push_back(mk("hit3", 0, 8'h00, 0, 0, 11, 1, 0, 0, 0, 0));
        tbl.push_back(mk("hit3", 0, 8'h00, 0, 0, 12, 1, 0, 0, 0, 0));
        tbl.push_back(mk("hit3", 0, 8'h00, 0, 0,  7, 1, 0, 0, 0, 0));

        // serve after point_end with has_serve
        tbl.push_back(mk("pe_serve", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("s_idle",   0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("serve", 0, K_H,   1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("serve", 0, 8'h00, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("serve_shoot", 0, 8'h00, 1, 0, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk("serve", 0, K_H,   1, 0, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk("serve", 0, 8'h00, 1, 0, 5, 1, 0, 0, 0, 0));
        tbl.push_back(mk("serve", 0, 8'h00, 1, 0, 6, 1, 0, 0, 0, 0));
        tbl.push_back(mk("serve_end", 0, 8'h00, 1, 0, 7, 1, 0, 0, 0, 0));

        // receive-side moves
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk("move_r", 0, K_R, 0, 0, 13, 1, 0, 0, 0, 1));
            tbl.push_back(mk("move_r", 0, K_R, 0, 0, 14, 1, 0, 0, 0, 0));
            tbl.push_back(mk("move_r", 0, K_R, 0, 0, 15, 1, 0, 0, 0, 0));
            tbl.push_back(mk("move_r_gap", 0, K_R, 0, 0, 7, 1, 0, 0, 0, 0));
        end
        tbl.push_back(mk("move_l", 0, K_L, 0, 0, 15, 1, 0, 0, 1, 0));
        tbl.push_back(mk("move_l", 0, K_L, 0, 0, 14, 1, 0, 0, 0, 0));
        tbl.push_back(mk("move_l", 0, K_L, 0, 0, 13, 1, 0, 0, 0, 0));
        tbl.push_back(mk("move_l", 0, K_L, 0, 0,  7, 1, 0, 0, 0, 0));
        tbl.push_back(mk("r_idle", 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0));

        // serve-side moves and an unmapped key
        tbl.push_back(mk("pe_serve2", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("s_move_l", 0, K_L,   1, 0, 18, 0, 0, 0, 1, 0));
        tbl.push_back(mk("s_move_l", 0, 8'h00, 1, 0, 17, 0, 0, 0, 0, 0));
        tbl.push_back(mk("s_move_l", 0, 8'h00, 1, 0, 16, 0, 0, 0, 0, 0));
        tbl.push_back(mk("s_move_l", 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("s_move_r", 0, K_R,   1, 0, 16, 0, 0, 0, 0, 1));
        tbl.push_back(mk("s_move_r", 0, 8'h00, 1, 0, 17, 0, 0, 0, 0, 0));
        tbl.push_back(mk("s_move_r", 0, 8'h00, 1, 0, 18, 0, 0, 0, 0, 0));
        tbl.push_back(mk("s_move_r", 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("other_key", 0, 8'h22, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("other_key", 0, 8'h22, 1, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

        // point_end aborts a hit mid-swing; a fresh press right after is accepted
        drive(mk("pe_recv",   0, 8'h00, 0, 1, 7, 1, 0, 0, 0, 0));
        drive(mk("abort_hit", 0, K_H,   0, 0, 8, 1, 0, 1, 0, 0));
        drive(mk("abort_hit", 0, 8'h00, 0, 0, 9, 1, 0, 1, 0, 0));
        drive(mk("abort_pe",  0, 8'h00, 0, 1, 7, 1, 0, 0, 0, 0));
        drive(mk("rehit", 0, K_H,   0, 0,  8, 1, 0, 1, 0, 0));
        drive(mk("rehit", 0, 8'h00, 0, 0,  9, 1, 0, 1, 0, 0));
        drive(mk("rehit", 0, 8'h00, 0, 0, 10, 1, 0, 1, 0, 0));
        drive(mk("rehit", 0, 8'h00, 0, 0, 11, 1, 0, 0, 0, 0));
        drive(mk("rehit", 0, 8'h00, 0, 0, 12, 1, 0, 0, 0, 0));
        drive(mk("rehit", 0, 8'h00, 0, 0,  7, 1, 0, 0, 0, 0));

        // long idle on the serving side
        drive(mk("pe_auto", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 125; i++) begin
`ifdef PLAYER_AUTO_SERVE_EN
            if (i < 120)       drive(mk("auto_wait",  0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
            else if (i == 122) drive(mk("auto_shoot", 0, 8'h00, 1, 0, 3, 1, 1, 0, 0, 0));
            else               drive(mk("auto_swing", 0, 8'h00, 1, 0, i - 119, (i > 122) ? 1'b1 : 1'b0, 0, 0, 0, 0));
`else
            drive(mk("no_auto", 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
`endif
        end

        repeat (3) @(posedge frame_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
